// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction-memory loader.
// The master is the program source and the slave is the loader.
interface imem_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to imem from address 0.
// It then zero-fills the remaining words and raises start_o for the CPU.
module imem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    imem_loader_if.slave      in_if,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              start_o,
    output logic              done_o,
    output logic              error_o
);

    typedef enum logic [1:0] {StLoad, StFill, StRun, StErr} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [31:0]         asm_q, asm_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                xfer;
    logic [31:0]         word_v;

    assign in_if.in_ready = (state_q == StLoad);
    assign xfer           = in_if.in_valid && in_if.in_ready;
    // Upper bytes of the assembler are always zero here, so a short word comes out zero-padded.
    assign word_v         = asm_q | ({24'd0, in_if.in_data} << {byte_idx_q, 3'b000});

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        ptr_d      = ptr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cnt_d      = cnt_q;
        // Status lags the state by one cycle so it never overlaps the final write pulse.
        start_d    = (state_q == StRun);
        done_d     = (state_q == StRun);
        err_d      = (state_q == StErr);

        unique case (state_q)
            StLoad: begin
                if (xfer) begin
                    if (byte_idx_q == 2'd3 || in_if.in_last) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = ptr_q;
                        wr_data_d  = word_v;
                        cnt_d      = cnt_q + (ADDR_W+1)'(1);
                        byte_idx_d = 2'd0;
                        asm_d      = 32'd0;
                        if (byte_idx_q != 2'd3) begin
                            state_d = StErr;
                        end else if (in_if.in_last) begin
                            if (ptr_q == LastAddr) begin
                                state_d = StRun;
                            end else begin
                                state_d = StFill;
                                ptr_d   = ptr_q + ADDR_W'(1);
                            end
                        end else if (ptr_q == LastAddr) begin
                            state_d = StErr;
                        end else begin
                            ptr_d = ptr_q + ADDR_W'(1);
                        end
                    end else begin
                        asm_d      = word_v;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            StFill: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = 32'd0;
                if (ptr_q == LastAddr) begin
                    state_d = StRun;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            StRun, StErr: begin
            end
            default: state_d = StErr;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StLoad;
            byte_idx_q <= 2'd0;
            asm_q      <= 32'd0;
            ptr_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'd0;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            ptr_q      <= ptr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign word_cnt_o = cnt_q;
    assign start_o    = start_q;
    assign done_o     = done_q;
    assign error_o    = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with DEPTH=8: nominal, gaps, full, overflow, misaligned, reset.
// Expected words are hand-computed; a negedge monitor logs writes and transfers.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   word_cnt;
    logic              start, done, error;

    imem_loader_if u_if ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_if      (u_if),
        .wr_en_o    (wr_en),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .word_cnt_o (word_cnt),
        .start_o    (start),
        .done_o     (done),
        .error_o    (error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          start_cyc = -1;
    int          overlap = 0;
    int          wlog_addr[$];
    logic [31:0] wlog_data[$];
    int          wlog_cyc[$];
    int          xfer_cyc[$];
    logic [7:0]  prog[0:63];
    logic [31:0] exp_data[0:7];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr_en) begin
            wlog_addr.push_back(int'(wr_addr));
            wlog_data.push_back(wr_data);
            wlog_cyc.push_back(cyc);
        end
        if (u_if.in_valid && u_if.in_ready) xfer_cyc.push_back(cyc);
        if (start && start_cyc < 0) start_cyc = cyc;
        if (start && wr_en) overlap = overlap + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wlog_addr.delete();
        wlog_data.delete();
        wlog_cyc.delete();
        xfer_cyc.delete();
        start_cyc = -1;
        overlap   = 0;
    endtask

    // Leaves the bench 1 time unit after a rising edge, the point where inputs are driven.
    task automatic do_reset();
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
        u_if.in_data  = 8'h00;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        #1 check_eq("ready after reset", 64'(u_if.in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_prog(input int n, input int last_pos, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                u_if.in_valid = 1'b0;
                u_if.in_data  = 8'hEE;
                u_if.in_last  = 1'b1;
                @(posedge clk);
                #1;
            end
            u_if.in_valid = 1'b1;
            u_if.in_data  = prog[i];
            u_if.in_last  = (i == last_pos);
            @(posedge clk);
            #1;
        end
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
    endtask

    task automatic settle();
        repeat (20) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input int n);
        check_eq({tag, " nwrites"}, 64'(wlog_addr.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s addr%0d", tag, i),
                     (i < wlog_addr.size()) ? 64'(wlog_addr[i]) : 64'hFFFF, 64'(i));
            check_eq($sformatf("%s data%0d", tag, i),
                     (i < wlog_data.size()) ? 64'(wlog_data[i]) : 64'hDEAD_BEEF_0, 64'(exp_data[i]));
        end
    endtask

    task automatic load_nominal();
        prog[0] = 8'h13; prog[1] = 8'h05; prog[2] = 8'h00; prog[3] = 8'h00;
        prog[4] = 8'h93; prog[5] = 8'h02; prog[6] = 8'hA0; prog[7] = 8'h00;
        exp_data[0] = 32'h0000_0513;
        exp_data[1] = 32'h00A0_0293;
        for (int i = 2; i < 8; i++) exp_data[i] = 32'd0;
    endtask

    task automatic check_run(input string tag, input int cnt);
        check_eq({tag, " start"}, 64'(start), 64'd1);
        check_eq({tag, " done"}, 64'(done), 64'd1);
        check_eq({tag, " error"}, 64'(error), 64'd0);
        check_eq({tag, " ready"}, 64'(u_if.in_ready), 64'd0);
        check_eq({tag, " wcnt"}, 64'(word_cnt), 64'(cnt));
        check_eq({tag, " overlap"}, 64'(overlap), 64'd0);
        if (wlog_cyc.size() == 8)
            check_eq({tag, " start lat"}, 64'(start_cyc), 64'(wlog_cyc[7] + 1));
        else
            check_eq({tag, " start lat nwr"}, 64'(wlog_cyc.size()), 64'd8);
    endtask

    initial begin
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
        u_if.in_data  = 8'h00;
        #1 rst = 1'b1;
        #1;
        check_eq("rst wr_en", 64'(wr_en), 64'd0);
        check_eq("rst wr_addr", 64'(wr_addr), 64'd0);
        check_eq("rst wr_data", 64'(wr_data), 64'd0);
        check_eq("rst wcnt", 64'(word_cnt), 64'd0);
        check_eq("rst status", 64'({start, done, error}), 64'd0);

        // Nominal two-word load followed by zero fill.
        do_reset();
        load_nominal();
        send_prog(8, 7, 1'b0);
        settle();
        check_writes("t1", 8);
        if (wlog_cyc.size() == 8 && xfer_cyc.size() == 8) begin
            check_eq("t1 wr latency", 64'(wlog_cyc[1]), 64'(xfer_cyc[7] + 1));
            check_eq("t1 fill follows", 64'(wlog_cyc[2]), 64'(wlog_cyc[1] + 1));
            check_eq("t1 fill span", 64'(wlog_cyc[7] - wlog_cyc[2]), 64'd5);
        end else begin
            check_eq("t1 log sizes", 64'({wlog_cyc.size(), xfer_cyc.size()}),
                     64'({32'd8, 32'd8}));
        end
        check_run("t1", 2);

        // Same stream with valid low every other cycle.
        do_reset();
        load_nominal();
        send_prog(8, 7, 1'b1);
        settle();
        check_writes("t2", 8);
        check_run("t2", 2);

        // Full program: 32 bytes, no zero fill.
        do_reset();
        for (int i = 0; i < 64; i++) prog[i] = 8'(i);
        for (int k = 0; k < 8; k++)
            exp_data[k] = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
        send_prog(32, 31, 1'b0);
        settle();
        check_writes("t3", 8);
        check_eq("t3 word7", 64'(exp_data[7]), 64'h1F1E_1D1C);
        check_run("t3", 8);

        // Overflow: 36 bytes into an 8-word memory.
        do_reset();
        send_prog(36, 35, 1'b0);
        settle();
        check_writes("t4", 8);
        check_eq("t4 error", 64'(error), 64'd1);
        check_eq("t4 ready", 64'(u_if.in_ready), 64'd0);
        check_eq("t4 start", 64'(start), 64'd0);
        check_eq("t4 done", 64'(done), 64'd0);
        check_eq("t4 wcnt", 64'(word_cnt), 64'd8);

        // Last flag on the second byte of the second word.
        do_reset();
        prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33;
        prog[3] = 8'h44; prog[4] = 8'h55; prog[5] = 8'h66;
        exp_data[0] = 32'h4433_2211;
        exp_data[1] = 32'h0000_6655;
        send_prog(6, 5, 1'b0);
        settle();
        check_writes("t5", 2);
        check_eq("t5 wcnt", 64'(word_cnt), 64'd2);
        check_eq("t5 error", 64'(error), 64'd1);
        check_eq("t5 start", 64'(start), 64'd0);
        check_eq("t5 ready", 64'(u_if.in_ready), 64'd0);

        // Asynchronous reset after three bytes of word 1, then a clean reload.
        do_reset();
        load_nominal();
        send_prog(7, -1, 1'b0);
        check_eq("t6 pre wcnt", 64'(word_cnt), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6 wr_en", 64'(wr_en), 64'd0);
        check_eq("t6 wr_addr", 64'(wr_addr), 64'd0);
        check_eq("t6 wr_data", 64'(wr_data), 64'd0);
        check_eq("t6 wcnt", 64'(word_cnt), 64'd0);
        check_eq("t6 status", 64'({start, done, error}), 64'd0);
        do_reset();
        send_prog(8, 7, 1'b0);
        settle();
        check_writes("t6 reload", 8);
        check_run("t6 reload", 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
